// File: rtl/mdu_div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// Produces one quotient bit per cycle and stalls E until the result is ready.
module mdu_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             div_stall_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] prem_step;
  logic [WIDTH-1:0] dvd_step;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // dvd_q doubles as the quotient register: dividend bits shift out, quotient bits shift in
  always_comb begin
    shifted   = {prem_q, dvd_q[WIDTH-1]};
    trial     = shifted - {1'b0, dvs_q};
    qbit      = ~trial[WIDTH];
    prem_step = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_step  = {dvd_q[WIDTH-2:0], qbit};
    abs_a     = (signed_i & opa_i[WIDTH-1]) ? -opa_i : opa_i;
    abs_b     = (signed_i & opb_i[WIDTH-1]) ? -opb_i : opb_i;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prem_d     = prem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            neg_quot_d = signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
            neg_rem_d  = signed_i & opa_i[WIDTH-1];
            dvd_d      = abs_a;
            dvs_d      = abs_b;
            prem_d     = '0;
            cnt_d      = '0;
            if (opb_i == '0) begin
              quot_d  = '1;
              rem_d   = opa_i;
              state_d = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!start_i) begin
            state_d = S_IDLE;
          end else begin
            prem_d = prem_step;
            dvd_d  = dvd_step;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              quot_d  = neg_quot_q ? -dvd_step : dvd_step;
              rem_d   = neg_rem_q ? -prem_step : prem_step;
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!stall_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prem_q     <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prem_q     <= prem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
    end
  end

  // resetn term keeps the stall request quiet while the block is held in reset
  assign div_stall_o = resetn & start_i & ~flush_i & (state_q != S_DONE);
  assign ready_o     = (state_q == S_DONE);
  assign quot_o      = quot_q;
  assign rem_o       = rem_q;

endmodule

// File: tb/tb_mdu_div_iter.sv
// Directed testbench for mdu_div_iter: latency, signed/unsigned results, flush, stall, reset.
module tb_mdu_div_iter;

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic        stall_i;
  logic        flush_i;
  logic        div_stall_o;
  logic        ready_o;
  logic [31:0] quot_o;
  logic [31:0] rem_o;

  int n_cmp = 0;
  int n_err = 0;

  mdu_div_iter #(.WIDTH(32)) u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .opa_i       (opa_i),
    .opb_i       (opb_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .div_stall_o (div_stall_o),
    .ready_o     (ready_o),
    .quot_o      (quot_o),
    .rem_o       (rem_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; outputs are sampled 1ns later, well away from posedge.
  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_q,
                         input logic [31:0] exp_r, input int exp_lat, input int hold);
    int n;
    int sc;
    n  = 0;
    sc = 0;
    @(negedge clk);
    signed_i = sgn;
    opa_i    = a;
    opb_i    = b;
    start_i  = 1'b1;
    #1;
    while (!ready_o && n < 100) begin
      if (div_stall_o) sc++;
      next_cyc();
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
    chk({tag, ".stallcyc"}, 32'(sc), 32'(exp_lat));
    chk({tag, ".quot"}, quot_o, exp_q);
    chk({tag, ".rem"}, rem_o, exp_r);
    chk({tag, ".stall_done"}, 32'(div_stall_o), 32'd0);
    if (hold > 0) begin
      stall_i = 1'b1;
      for (int i = 0; i < hold; i++) begin
        next_cyc();
        chk({tag, ".hold_rdy"}, 32'(ready_o), 32'd1);
        chk({tag, ".hold_q"}, quot_o, exp_q);
        chk({tag, ".hold_r"}, rem_o, exp_r);
        chk({tag, ".hold_stall"}, 32'(div_stall_o), 32'd0);
      end
      stall_i = 1'b0;
    end
    start_i = 1'b0;
    next_cyc();
    chk({tag, ".idle_rdy"}, 32'(ready_o), 32'd0);
    chk({tag, ".idle_q"}, quot_o, exp_q);
  endtask

  initial begin
    resetn   = 1'b0;
    start_i  = 1'b0;
    signed_i = 1'b0;
    opa_i    = '0;
    opb_i    = '0;
    stall_i  = 1'b0;
    flush_i  = 1'b0;
    #2;
    chk("rst.rdy", 32'(ready_o), 32'd0);
    chk("rst.quot", quot_o, 32'd0);
    chk("rst.rem", rem_o, 32'd0);
    chk("rst.stall", 32'(div_stall_o), 32'd0);
    next_cyc();
    resetn = 1'b1;
    next_cyc();

    run_div("divu100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 5);
    run_div("divu_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 33, 0);
    run_div("divu_msb_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 0);
    run_div("div_5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 0);

    // flush mid-divide
    @(negedge clk);
    signed_i = 1'b0;
    opa_i    = 32'd100;
    opb_i    = 32'd7;
    start_i  = 1'b1;
    for (int i = 0; i < 10; i++) next_cyc();
    flush_i = 1'b1;
    #1;
    chk("flush.stall", 32'(div_stall_o), 32'd0);
    next_cyc();
    chk("flush.rdy", 32'(ready_o), 32'd0);
    chk("flush.quot_hold", quot_o, 32'hFFFF_FFFF);
    flush_i = 1'b0;
    start_i = 1'b0;
    next_cyc();
    chk("flush.idle_rdy", 32'(ready_o), 32'd0);
    run_div("divu9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 0);

    // async reset mid-divide
    @(negedge clk);
    signed_i = 1'b0;
    opa_i    = 32'd100;
    opb_i    = 32'd7;
    start_i  = 1'b1;
    for (int i = 0; i < 15; i++) next_cyc();
    #1;
    resetn = 1'b0;
    #1;
    chk("amid_rst.rdy", 32'(ready_o), 32'd0);
    chk("amid_rst.quot", quot_o, 32'd0);
    chk("amid_rst.rem", rem_o, 32'd0);
    chk("amid_rst.stall", 32'(div_stall_o), 32'd0);
    start_i = 1'b0;
    next_cyc();
    resetn = 1'b1;
    next_cyc();
    chk("post_rst.rdy", 32'(ready_o), 32'd0);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
